// File: rtl/camera_pkg.sv
// Shared types for the camera pan sequencer: view codes, FSM states and
// conversions between view codes and signed positions (-1, 0, +1).
package camera_pkg;

   typedef enum logic [1:0] {
      VIEW_FWD   = 2'd0,
      VIEW_LEFT  = 2'd1,
      VIEW_RIGHT = 2'd2
   } view_t;

   typedef enum logic {
      S_IDLE,
      S_PAN
   } state_t;

   typedef logic signed [1:0] pos_t;

   localparam pos_t POS_LEFT  = 2'sb11;
   localparam pos_t POS_FWD   = 2'sb00;
   localparam pos_t POS_RIGHT = 2'sb01;

   function automatic pos_t view_to_pos(input view_t v);
      case (v)
         VIEW_LEFT:  return POS_LEFT;
         VIEW_RIGHT: return POS_RIGHT;
         default:    return POS_FWD;
      endcase
   endfunction

   function automatic view_t pos_to_view(input pos_t p);
      case (p)
         POS_LEFT:  return VIEW_LEFT;
         POS_RIGHT: return VIEW_RIGHT;
         default:   return VIEW_FWD;
      endcase
   endfunction

endpackage

// File: rtl/camera_pan_sequencer_if.sv
// Button/frame inputs and view/pan outputs shared between the sequencer
// and its neighbours (board buttons, renderer).
interface camera_pan_sequencer_if #(
   parameter int OFS_W = 12
) ();

   logic                    left_btn;
   logic                    right_btn;
   logic                    frame_tick;
   logic [1:0]              view;
   logic signed [OFS_W-1:0] pan_offset;
   logic                    busy;
   logic                    pend_valid;

   modport master (
      output left_btn, right_btn, frame_tick,
      input  view, pan_offset, busy, pend_valid
   );

   modport slave (
      input  left_btn, right_btn, frame_tick,
      output view, pan_offset, busy, pend_valid
   );

endinterface

// File: rtl/button_debouncer.sv
// Two-flop synchronizer, level debouncer and one-cycle rising-edge pulse
// for a single raw push-button.
module button_debouncer #(
   parameter int DEB_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic req
);

   localparam int CNT_W = $clog2(DEB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic [1:0]       sync_q;
   logic             level_q;
   logic             level_d_q;
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q    <= '0;
         level_q   <= 1'b0;
         level_d_q <= 1'b0;
         cnt_q     <= '0;
         req       <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], btn};
         // Any cycle where the synced input agrees with the level restarts the count.
         if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
               level_q <= sync_q[1];
               cnt_q   <= '0;
            end else begin
               cnt_q <= cnt_q + CNT_W'(1);
            end
         end else begin
            cnt_q <= '0;
         end
         level_d_q <= level_q;
         req       <= level_q & ~level_d_q;
      end
   end

endmodule

// File: rtl/camera_pan_sequencer.sv
// Turns debounced left/right presses into frame-stepped pans between the
// LEFT, FWD and RIGHT views, with a single-entry request queue.
module camera_pan_sequencer
   import camera_pkg::*;
#(
   parameter int PAN_DIST   = 640,
   parameter int STEP       = 16,
   parameter int DEB_CYCLES = 500000,
   parameter int OFS_W      = 12
) (
   input  logic                   clk,
   input  logic                   rst_n,
   camera_pan_sequencer_if.slave  bus
);

   localparam logic signed [OFS_W-1:0] DIST_S = OFS_W'(PAN_DIST);
   localparam logic signed [OFS_W-1:0] STEP_S = OFS_W'(STEP);

   logic req_l, req_r;

   button_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb_l (
      .clk(clk), .rst_n(rst_n), .btn(bus.left_btn), .req(req_l)
   );

   button_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb_r (
      .clk(clk), .rst_n(rst_n), .btn(bus.right_btn), .req(req_r)
   );

   state_t                  state_q, state_nxt;
   view_t                   view_q, view_nxt;
   pos_t                    tgt_q, tgt_nxt;
   pos_t                    ptgt_q, ptgt_nxt;
   logic                    pend_q, pend_nxt;
   logic signed [OFS_W-1:0] ofs_q, ofs_nxt;
   logic signed [OFS_W-1:0] goal, stepped;

   // A request is judged against where the camera will be when it executes.
   pos_t base, new_pos;
   logic req_ok;

   assign base    = (state_q == S_PAN) ? tgt_q : (pend_q ? ptgt_q : view_to_pos(view_q));
   assign req_ok  = (req_l ^ req_r) &
                    ~((req_l & (base == POS_LEFT)) | (req_r & (base == POS_RIGHT)));
   assign new_pos = base + (req_l ? POS_LEFT : POS_RIGHT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         view_q  <= VIEW_FWD;
         tgt_q   <= POS_FWD;
         ptgt_q  <= POS_FWD;
         pend_q  <= 1'b0;
         ofs_q   <= '0;
      end else begin
         state_q <= state_nxt;
         view_q  <= view_nxt;
         tgt_q   <= tgt_nxt;
         ptgt_q  <= ptgt_nxt;
         pend_q  <= pend_nxt;
         ofs_q   <= ofs_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      view_nxt  = view_q;
      tgt_nxt   = tgt_q;
      ptgt_nxt  = ptgt_q;
      pend_nxt  = pend_q;
      ofs_nxt   = ofs_q;
      goal      = '0;
      stepped   = ofs_q;

      case (tgt_q)
         POS_LEFT:  goal = -DIST_S;
         POS_RIGHT: goal = DIST_S;
         default:   goal = '0;
      endcase

      case (state_q)
         S_IDLE: begin
            if (pend_q) begin
               state_nxt = S_PAN;
               tgt_nxt   = ptgt_q;
               pend_nxt  = req_ok;
               ptgt_nxt  = req_ok ? new_pos : ptgt_q;
            end else if (req_ok) begin
               state_nxt = S_PAN;
               tgt_nxt   = new_pos;
            end
         end
         S_PAN: begin
            if (req_ok && !pend_q) begin
               pend_nxt = 1'b1;
               ptgt_nxt = new_pos;
            end
            if (bus.frame_tick) begin
               if (ofs_q < goal) begin
                  stepped = ofs_q + STEP_S;
                  if (stepped > goal) stepped = goal;
               end else begin
                  stepped = ofs_q - STEP_S;
                  if (stepped < goal) stepped = goal;
               end
               ofs_nxt = stepped;
               if (stepped == goal) begin
                  view_nxt  = pos_to_view(tgt_q);
                  state_nxt = S_IDLE;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign bus.view       = view_q;
   assign bus.pan_offset = ofs_q;
   assign bus.busy       = (state_q == S_PAN);
   assign bus.pend_valid = pend_q;

endmodule

// File: tb/tb_camera_pan_sequencer.sv
// Directed bench for camera_pan_sequencer with a short debounce window.
module tb_camera_pan_sequencer;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   camera_pan_sequencer_if #(.OFS_W(12)) bif ();

   camera_pan_sequencer #(
      .PAN_DIST(640), .STEP(16), .DEB_CYCLES(4), .OFS_W(12)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bif)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, required finish before 200000 ns");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic press(input logic l, input logic r);
      @(negedge clk);
      bif.left_btn  = l;
      bif.right_btn = r;
      repeat (6) @(negedge clk);
      bif.left_btn  = 1'b0;
      bif.right_btn = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bif.frame_tick = 1'b1;
         @(negedge clk);
         bif.frame_tick = 1'b0;
      end
   endtask

   initial begin
      rst_n          = 1'b0;
      bif.left_btn   = 1'b0;
      bif.right_btn  = 1'b0;
      bif.frame_tick = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_view", bif.view, 0);
      check("rst_offset", bif.pan_offset, 0);
      check("rst_busy", bif.busy, 0);
      check("rst_pend", bif.pend_valid, 0);
      rst_n = 1'b1;
      @(negedge clk);

      tick(2);
      check("idle_tick_offset", bif.pan_offset, 0);
      check("idle_tick_busy", bif.busy, 0);

      // FWD -> LEFT, checking every step
      press(1'b1, 1'b0);
      check("left_busy", bif.busy, 1);
      check("left_offset0", bif.pan_offset, 0);
      check("left_view0", bif.view, 0);
      for (int k = 1; k <= 40; k++) begin
         tick(1);
         check("left_step", bif.pan_offset, -16 * k);
         if (k == 39) begin
            check("left_busy39", bif.busy, 1);
            check("left_view39", bif.view, 0);
         end
      end
      check("left_view", bif.view, 1);
      check("left_done_busy", bif.busy, 0);

      // Left while already at LEFT is ignored
      press(1'b1, 1'b0);
      check("edge_busy", bif.busy, 0);
      check("edge_view", bif.view, 1);
      check("edge_offset", bif.pan_offset, -640);
      check("edge_pend", bif.pend_valid, 0);

      press(1'b0, 1'b1);
      check("back_busy", bif.busy, 1);
      tick(40);
      check("back_view", bif.view, 0);
      check("back_offset", bif.pan_offset, 0);
      check("back_busy_done", bif.busy, 0);

      // FWD -> RIGHT with a queued reversal and a dropped extra request
      press(1'b0, 1'b1);
      tick(5);
      check("r_offset5", bif.pan_offset, 80);
      press(1'b1, 1'b0);
      check("q_pend", bif.pend_valid, 1);
      check("q_busy", bif.busy, 1);
      check("q_offset", bif.pan_offset, 80);
      press(1'b0, 1'b1);
      check("q_pend_full", bif.pend_valid, 1);
      tick(35);
      check("r_offset", bif.pan_offset, 640);
      check("r_view", bif.view, 2);
      check("r_gap_busy", bif.busy, 0);
      check("r_gap_pend", bif.pend_valid, 1);
      @(negedge clk);
      check("relaunch_busy", bif.busy, 1);
      check("relaunch_pend", bif.pend_valid, 0);
      check("relaunch_offset", bif.pan_offset, 640);
      tick(40);
      check("ret_offset", bif.pan_offset, 0);
      check("ret_view", bif.view, 0);
      check("ret_busy", bif.busy, 0);
      check("ret_pend", bif.pend_valid, 0);
      repeat (5) @(negedge clk);
      check("no_extra_busy", bif.busy, 0);

      press(1'b1, 1'b1);
      check("both_busy", bif.busy, 0);
      check("both_pend", bif.pend_valid, 0);
      check("both_view", bif.view, 0);

      // 3-cycle glitch on the right button
      @(negedge clk);
      bif.right_btn = 1'b1;
      repeat (3) @(negedge clk);
      bif.right_btn = 1'b0;
      repeat (10) @(negedge clk);
      check("glitch_busy", bif.busy, 0);
      check("glitch_view", bif.view, 0);

      // Asynchronous reset in the middle of a pan
      press(1'b0, 1'b1);
      tick(20);
      check("mid_offset", bif.pan_offset, 320);
      check("mid_busy", bif.busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_offset", bif.pan_offset, 0);
      check("arst_view", bif.view, 0);
      check("arst_busy", bif.busy, 0);
      check("arst_pend", bif.pend_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_busy", bif.busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/camera_pan_sequencer.md
# camera_pan_sequencer

Sequences first-person camera turns for the renderer. Left/right push-buttons are synchronized, debounced and turned into turn requests. Each accepted turn becomes a smooth horizontal pan, one step per video frame, between three fixed views (LEFT, FWD, RIGHT). The block sits between the board buttons and the background/sprite renderer, which consumes `view`, `pan_offset` and `busy`.

## Interface
Parameters:
- `PAN_DIST`, 640: pixel distance between adjacent views.
- `STEP`, 16: pixels moved per frame tick. Must evenly divide `PAN_DIST`.
- `DEB_CYCLES`, 500000: consecutive stable cycles required to accept a button level change.
- `OFS_W`, 12: width of `pan_offset` (signed; must hold ±`PAN_DIST`).

Ports:
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `left_btn`, in, 1: raw left button, asynchronous to `clk`.
- `right_btn`, in, 1: raw right button, asynchronous to `clk`.
- `frame_tick`, in, 1: one-cycle pulse per frame (start of vblank).
- `view`, out, 2: committed view. FWD=2'd0, LEFT=2'd1, RIGHT=2'd2.
- `pan_offset`, out, `OFS_W`: signed scroll offset. LEFT=−`PAN_DIST`, FWD=0, RIGHT=+`PAN_DIST`.
- `busy`, out, 1: high while a pan is in progress.
- `pend_valid`, out, 1: a queued request is waiting.

## Operation
- **Input conditioning:** each button passes through a 2-flop synchronizer and then a debouncer. The debounced level changes only after the synced input differs from it for `DEB_CYCLES` consecutive cycles. A debounced rising edge produces a 1-cycle request pulse (`req_l`, `req_r`).
- **View position:** LEFT=−1, FWD=0, RIGHT=+1. Left request means position −1; right request means position +1.
- **Request validity:**
  - Left at LEFT and right at RIGHT are invalid and dropped silently.
  - Validity is checked against the position the camera will be at when the request executes: the current target if busy, the current view if idle.
- **Simultaneous requests:** `req_l` and `req_r` in the same cycle are both dropped.
- **State machine:**
  - IDLE, valid request: latch target = view ± 1 and go to PAN.
  - IDLE with `pend_valid`: launch the pending request and clear `pend_valid`. A new request in that same cycle goes to the empty queue slot if valid.
  - PAN, on `frame_tick`: move `pan_offset` by `STEP` toward target × `PAN_DIST`, saturating exactly at the target.
  - PAN, offset reaches target: on that edge, `view` ← target and go to IDLE.
  - PAN, valid request with queue empty: store it in the single-entry queue (`pend_valid`=1). Requests arriving while the queue is full are dropped.
  - A reversal request (opposite direction) during PAN is queued, not applied mid-pan.
- **Reset values:** `view`=FWD, `pan_offset`=0, `busy`=0, `pend_valid`=0, state=IDLE, debouncer levels=0, debounce counters=0. Reset mid-pan aborts immediately to these values. A button held through reset release produces a request only after `DEB_CYCLES`.

## Timing
- Debounced edge to request pulse: 1 cycle.
- Request pulse to PAN entry: next edge; `busy`=1 from that edge.
- Each `frame_tick` in PAN changes `pan_offset` at the same edge it is sampled.
- One view change takes `PAN_DIST`/`STEP` frame ticks (40 at defaults).
- `view` and `busy`=0 update on the edge of the final step.
- A pending request keeps `busy` low for exactly 1 cycle, then re-enters PAN.
- `frame_tick` while IDLE has no effect.

## Structure
- **Package `camera_pkg`:**
  - view codes (VIEW_FWD, VIEW_LEFT, VIEW_RIGHT);
  - sequencer state enum (S_IDLE, S_PAN);
  - view-to-signed-position helper function.
- **Sub-module `button_debouncer`:** synchronizer, counter and rising-edge pulse, parameterized by `DEB_CYCLES`. Instantiated once per button.
- **Top level:** request validation, single-entry queue, pan FSM, offset stepping.

## Test plan
Benches use `DEB_CYCLES`=4, `STEP`=16, `PAN_DIST`=640.
- Reset, hold left 6 cycles, tick frames → `busy` rises; `pan_offset` goes 0, −16 … −640 over 40 ticks; `view`=LEFT with `busy`=0 on tick 40.
- Left pulse while at LEFT → no `busy`; `view` and `pan_offset` unchanged.
- During a FWD→RIGHT pan, press left then right → left is queued (`pend_valid`=1) and right is dropped. After arrival at RIGHT: `busy`=0 for 1 cycle, then the pan returns to `pan_offset`=0 and `view`=FWD.
- Both buttons pressed in the same cycle → both dropped; state stays IDLE.
- Glitch of 3 cycles on `right_btn` → no request.
- `rst_n` asserted at offset +320 mid-pan → same cycle: `pan_offset`=0, `view`=FWD, `busy`=0, `pend_valid`=0.
